// File: rtl/lcd_bus_arbiter.sv
// Two-port arbiter for the shared HD44780 4-bit LCD bus.
// Each granted byte is sent as a high nibble strobe and then a low nibble
// strobe. The bus then settles for a number of cycles that depends on the
// command, and after that the requester is acknowledged.
//
// Handshake (per port): the requester raises req with rs/byte stable and
// holds them until ack pulses for exactly one cycle. The arbiter never grants
// in a cycle where any ack is high, so a req still high during its own ack
// cycle is not served twice. Dropping req mid-transfer does not abort it.
module lcd_bus_arbiter #(
    parameter int SHORT_WAIT = 0,
    parameter int LONG_WAIT  = 2,
    parameter int WAIT_W     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       rs0,
    input  logic [7:0] byte0,
    output logic       ack0,
    input  logic       req1,
    input  logic       rs1,
    input  logic [7:0] byte1,
    output logic       ack1,
    output logic       busy,
    output logic       en,
    output logic       rs,
    output logic [3:0] data,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI   = 3'd1,
        ST_GAP  = 3'd2,
        ST_LO   = 3'd3,
        ST_WAIT = 3'd4
    } state_t;

    localparam logic [WAIT_W-1:0] SHORT_CNT = WAIT_W'(SHORT_WAIT);
    localparam logic [WAIT_W-1:0] LONG_CNT  = WAIT_W'(LONG_WAIT);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] counter;
    logic              last_grant;
    logic              cur_port;
    logic              cur_rs;
    logic [7:0]        cur_byte;

    logic grant_ok;
    logic grant_port;
    logic long_cmd;

    // A grant is only possible in IDLE, outside the one-cycle ack turnaround.
    assign grant_ok   = (state == ST_IDLE) && !ack0 && !ack1 && (req0 || req1);
    // On a tie the port that did not win last time is served.
    assign grant_port = (req0 && req1) ? ~last_grant : req1;
    // Clear display / return home need the long settle time.
    assign long_cmd   = !cur_rs && (cur_byte >= 8'h01) && (cur_byte <= 8'h03);
    assign fsm_state  = state;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: the transfer walks a fixed sequence and leaves WAIT when the counter is empty.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_ok) state_nxt = ST_HI;
            ST_HI:   state_nxt = ST_GAP;
            ST_GAP:  state_nxt = ST_LO;
            ST_LO:   state_nxt = ST_WAIT;
            ST_WAIT: if (counter == '0) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs and transfer datapath, updated per state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en         <= 1'b0;
            rs         <= 1'b0;
            data       <= 4'h0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            counter    <= '0;
            last_grant <= 1'b1;
            cur_port   <= 1'b0;
            cur_rs     <= 1'b0;
            cur_byte   <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (grant_ok) begin
                        cur_port   <= grant_port;
                        cur_rs     <= grant_port ? rs1 : rs0;
                        cur_byte   <= grant_port ? byte1 : byte0;
                        last_grant <= grant_port;
                        en         <= 1'b1;
                        rs         <= grant_port ? rs1 : rs0;
                        data       <= grant_port ? byte1[7:4] : byte0[7:4];
                        busy       <= 1'b1;
                    end
                end
                ST_HI: begin
                    en <= 1'b0;
                end
                ST_GAP: begin
                    en   <= 1'b1;
                    data <= cur_byte[3:0];
                end
                ST_LO: begin
                    en      <= 1'b0;
                    counter <= long_cmd ? LONG_CNT : SHORT_CNT;
                end
                ST_WAIT: begin
                    if (counter != '0) begin
                        counter <= counter - 1'b1;
                    end else begin
                        busy <= 1'b0;
                        if (cur_port) ack1 <= 1'b1;
                        else          ack0 <= 1'b1;
                    end
                end
                default: begin
                    en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter. Expected bus traces are built from
// a transaction-level model: each granted byte becomes a fixed cycle pattern
// whose length depends on the settle wait, and round-robin picks the winner.
module tb_lcd_bus_arbiter;

    localparam int SHORT_W = 0;
    localparam int LONG_W  = 2;

    logic       clk;
    logic       reset;
    logic       req0, rs0, req1, rs1;
    logic [7:0] byte0, byte1;
    logic       ack0, ack1, busy, en, rs;
    logic [3:0] data;
    logic [2:0] fsm_state;

    int n_checks;
    int n_fail;

    // Packed expected bus word: {en, rs, data[3:0], busy, ack0, ack1}
    logic [8:0] exp_q[$];

    // Model state: last bus values and last granted port
    logic       model_rs;
    logic [3:0] model_data;
    logic       model_last;

    lcd_bus_arbiter #(
        .SHORT_WAIT(SHORT_W),
        .LONG_WAIT (LONG_W),
        .WAIT_W    (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .rs0      (rs0),
        .byte0    (byte0),
        .ack0     (ack0),
        .req1     (req1),
        .rs1      (rs1),
        .byte1    (byte1),
        .ack1     (ack1),
        .busy     (busy),
        .en       (en),
        .rs       (rs),
        .data     (data),
        .fsm_state(fsm_state)
    );

    // Clock: 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_reset();
        model_rs   = 1'b0;
        model_data = 4'h0;
        model_last = 1'b1;
        exp_q.delete();
    endfunction

    // One byte on the bus: strobes at offsets 0 and 2, ack at offset 4+w.
    function automatic void push_transfer(input logic p, input logic r, input logic [7:0] b);
        int   w;
        logic e_en, e_busy, e_a0, e_a1;
        logic [3:0] e_data;
        w = (!r && b >= 8'h01 && b <= 8'h03) ? LONG_W : SHORT_W;
        for (int k = 0; k <= 4 + w; k++) begin
            e_en   = (k == 0) || (k == 2);
            e_data = (k < 2) ? b[7:4] : b[3:0];
            e_busy = (k < 4 + w);
            e_a0   = (k == 4 + w) && !p;
            e_a1   = (k == 4 + w) && p;
            exp_q.push_back({e_en, r, e_data, e_busy, e_a0, e_a1});
        end
        model_rs   = r;
        model_data = b[3:0];
        model_last = p;
    endfunction

    function automatic void push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, model_rs, model_data, 3'b000});
    endfunction

    task automatic test_reset();
        logic [8:0] e;
        int k;
        reset = 1'b1;
        req0 = 0; rs0 = 0; byte0 = 0;
        req1 = 0; rs1 = 0; byte1 = 0;
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", en); end
        n_checks++;
        if (rs !== 1'b0) begin n_fail++; $display("FAIL reset_rs: got %b expected 0", rs); end
        n_checks++;
        if (data !== 4'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", data); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if ({ack0, ack1} !== 2'b00) begin n_fail++; $display("FAIL reset_acks: got %b expected 00", {ack0, ack1}); end
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        push_idle(3);
        k = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({en, rs, data, busy, ack0, ack1} !== e) begin
                n_fail++;
                $display("FAIL reset_idle k=%0d: got %b expected %b", k, {en, rs, data, busy, ack0, ack1}, e);
            end
            k++;
        end
    endtask

    task automatic test_single_cmd();
        logic [8:0] e;
        int k;
        rs0 = 1'b0; byte0 = 8'h28; req0 = 1'b1;
        push_transfer(1'b0, 1'b0, 8'h28);
        push_idle(1);
        k = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({en, rs, data, busy, ack0, ack1} !== e) begin
                n_fail++;
                $display("FAIL single_cmd k=%0d: got %b expected %b", k, {en, rs, data, busy, ack0, ack1}, e);
            end
            if (e[1]) req0 = 1'b0;
            k++;
        end
    endtask

    task automatic test_clear_home();
        logic [8:0] e;
        int k;
        logic       t_rs[6];
        logic [7:0] t_b[6];
        t_rs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        t_b  = '{8'h01, 8'h01, 8'h03, 8'h04, 8'h00, 8'h02};
        for (int i = 0; i < 6; i++) begin
            rs0 = t_rs[i]; byte0 = t_b[i]; req0 = 1'b1;
            push_transfer(1'b0, t_rs[i], t_b[i]);
            push_idle(1);
            k = 0;
            while (exp_q.size() != 0) begin
                @(posedge clk); #1;
                e = exp_q.pop_front();
                n_checks++;
                if ({en, rs, data, busy, ack0, ack1} !== e) begin
                    n_fail++;
                    $display("FAIL clear_home byte=%h rs=%b k=%0d: got %b expected %b",
                             t_b[i], t_rs[i], k, {en, rs, data, busy, ack0, ack1}, e);
                end
                if (e[1]) req0 = 1'b0;
                k++;
            end
        end
    endtask

    // Port 1 character; req1 is dropped right after the grant and must still be acked.
    task automatic test_char();
        logic [8:0] e;
        int k;
        rs1 = 1'b1; byte1 = 8'h54; req1 = 1'b1;
        push_transfer(1'b1, 1'b1, 8'h54);
        push_idle(2);
        k = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({en, rs, data, busy, ack0, ack1} !== e) begin
                n_fail++;
                $display("FAIL char_T k=%0d: got %b expected %b", k, {en, rs, data, busy, ack0, ack1}, e);
            end
            if (k == 1) req1 = 1'b0;
            k++;
        end
    endtask

    // req0 stays high through the ack cycle and drops one cycle later.
    task automatic test_hold_through_ack();
        logic [8:0] e;
        int k;
        int ack_seen;
        rs0 = 1'b1; byte0 = 8'h41; req0 = 1'b1;
        push_transfer(1'b0, 1'b1, 8'h41);
        push_idle(4);
        k = 0;
        ack_seen = -1;
        while (exp_q.size() != 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({en, rs, data, busy, ack0, ack1} !== e) begin
                n_fail++;
                $display("FAIL hold_ack k=%0d: got %b expected %b", k, {en, rs, data, busy, ack0, ack1}, e);
            end
            if (ack_seen >= 0 && k == ack_seen + 1) req0 = 1'b0;
            if (e[1]) ack_seen = k;
            k++;
        end
    endtask

    task automatic test_random();
        logic [8:0] e;
        int k;
        logic       p, r;
        logic [7:0] b;
        for (int i = 0; i < 10; i++) begin
            p = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                r = 1'b0;
                b = 8'($urandom_range(1, 3));
            end
            if (p) begin rs1 = r; byte1 = b; req1 = 1'b1; end
            else   begin rs0 = r; byte0 = b; req0 = 1'b1; end
            push_transfer(p, r, b);
            push_idle(1);
            k = 0;
            while (exp_q.size() != 0) begin
                @(posedge clk); #1;
                e = exp_q.pop_front();
                n_checks++;
                if ({en, rs, data, busy, ack0, ack1} !== e) begin
                    n_fail++;
                    $display("FAIL random i=%0d port=%0d byte=%h k=%0d: got %b expected %b",
                             i, p, b, k, {en, rs, data, busy, ack0, ack1}, e);
                end
                if (e[1]) req0 = 1'b0;
                if (e[0]) req1 = 1'b0;
                k++;
            end
        end
    endtask

    // Both ports request continuously from reset release; grants must alternate.
    task automatic test_back_to_back();
        logic [8:0] e;
        int k;
        int i0, i1, acks;
        logic       p;
        logic       r0[2], r1[2];
        logic [7:0] b0[2], b1[2];
        for (int i = 0; i < 2; i++) begin
            r0[i] = 1'($urandom_range(0, 1)); b0[i] = 8'($urandom_range(0, 255));
            r1[i] = 1'($urandom_range(0, 1)); b1[i] = 8'($urandom_range(0, 255));
        end
        reset = 1'b0;
        rs0 = r0[0]; byte0 = b0[0]; req0 = 1'b1;
        rs1 = r1[0]; byte1 = b1[0]; req1 = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        i0 = 0; i1 = 0;
        for (int t = 0; t < 4; t++) begin
            p = ~model_last;
            if (p) begin push_transfer(1'b1, r1[i1], b1[i1]); i1++; end
            else   begin push_transfer(1'b0, r0[i0], b0[i0]); i0++; end
            push_idle(1);
        end
        push_idle(2);
        i0 = 0; i1 = 0; acks = 0; k = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({en, rs, data, busy, ack0, ack1} !== e) begin
                n_fail++;
                $display("FAIL back_to_back k=%0d: got %b expected %b", k, {en, rs, data, busy, ack0, ack1}, e);
            end
            if (e[1]) begin
                i0++; acks++;
                if (i0 < 2) begin rs0 = r0[i0]; byte0 = b0[i0]; end
            end
            if (e[0]) begin
                i1++; acks++;
                if (i1 < 2) begin rs1 = r1[i1]; byte1 = b1[i1]; end
            end
            if (acks == 4) begin req0 = 1'b0; req1 = 1'b0; end
            k++;
        end
    endtask

    // Reset asserted between clock edges while the FSM sits in GAP.
    task automatic test_reset_mid_gap();
        logic [8:0] e;
        int k;
        rs0 = 1'b1; byte0 = 8'h5A; req0 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if (en !== 1'b0) begin n_fail++; $display("FAIL midgap_en: got %b expected 0", en); end
        n_checks++;
        if (rs !== 1'b0) begin n_fail++; $display("FAIL midgap_rs: got %b expected 0", rs); end
        n_checks++;
        if (data !== 4'h0) begin n_fail++; $display("FAIL midgap_data: got %h expected 0", data); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midgap_busy: got %b expected 0", busy); end
        n_checks++;
        if ({ack0, ack1} !== 2'b00) begin n_fail++; $display("FAIL midgap_acks: got %b expected 00", {ack0, ack1}); end
        rs1 = 1'b1; byte1 = 8'h33; req1 = 1'b1;
        rs0 = 1'b0; byte0 = 8'h0C;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        push_transfer(1'b0, 1'b0, 8'h0C);
        push_idle(2);
        k = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({en, rs, data, busy, ack0, ack1} !== e) begin
                n_fail++;
                $display("FAIL midgap_regrant k=%0d: got %b expected %b", k, {en, rs, data, busy, ack0, ack1}, e);
            end
            if (e[1]) begin req0 = 1'b0; req1 = 1'b0; end
            k++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_cmd();
        test_clear_home();
        test_char();
        test_hold_through_ack();
        test_random();
        test_back_to_back();
        test_reset_mid_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
